// File: rtl/mii_mdio_poller.sv
// mii_mdio_poller: autonomous clause-22 MDIO master that reads one fixed PHY
// register forever, back to back.
// Ports:
//   clk         system clock, all logic on the rising edge
//   rst         synchronous active-high reset
//   MDC         management clock, CLK_DIV clk cycles per period, 50% duty
//   MDIO        management data; driven during PRE/ST/OP/PHYAD/REGAD, Z otherwise
//   rdata       last 16-bit register value read
//   rdata_valid one-clk pulse when rdata is updated
module mii_mdio_poller #(
    parameter int unsigned CLK_DIV      = 8,
    parameter logic [4:0]  PHY_ADDR     = 5'd0,
    parameter logic [4:0]  REG_ADDR     = 5'd1,
    parameter int unsigned PREAMBLE_LEN = 32,
    parameter int unsigned GAP_BITS     = 0
) (
    input  logic        clk,
    input  logic        rst,
    output logic        MDC,
    inout  wire         MDIO,
    output logic [15:0] rdata,
    output logic        rdata_valid
);

    localparam int unsigned HALF  = CLK_DIV / 2;
    localparam int unsigned DIV_W = $clog2(CLK_DIV);
    localparam int unsigned BIT_W = 8;

    typedef enum logic [2:0] {
        S_PRE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA, S_GAP
    } state_e;

    state_e             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [BIT_W-1:0]   bit_q, bit_d;
    logic               mdc_q, mdc_d;
    logic               oe_q, oe_d;
    logic               out_q, out_d;
    logic [15:0]        shift_q, shift_d;
    logic [15:0]        rdata_q, rdata_d;
    logic               valid_q, valid_d;
    logic               pend_q, pend_d;
    logic               rise, fall;
    logic               mdio_in;

    // Index of the last slot in each segment.
    function automatic logic [BIT_W-1:0] last_idx(input state_e s);
        case (s)
            S_PRE:            last_idx = BIT_W'(PREAMBLE_LEN - 1);
            S_PHYAD, S_REGAD: last_idx = BIT_W'(4);
            S_DATA:           last_idx = BIT_W'(15);
            S_GAP:            last_idx = BIT_W'(GAP_BITS - 1);
            default:          last_idx = BIT_W'(1);
        endcase
    endfunction

    function automatic state_e next_seg(input state_e s);
        case (s)
            S_PRE:   next_seg = S_ST;
            S_ST:    next_seg = S_OP;
            S_OP:    next_seg = S_PHYAD;
            S_PHYAD: next_seg = S_REGAD;
            S_REGAD: next_seg = S_TA;
            S_TA:    next_seg = S_DATA;
            S_DATA:  next_seg = (GAP_BITS == 0) ? S_PRE : S_GAP;
            default: next_seg = S_PRE;
        endcase
    endfunction

    // {output enable, value} for a slot; addresses go out MSB first.
    function automatic logic [1:0] drive(input state_e s, input logic [2:0] i);
        case (s)
            S_PRE:   drive = 2'b11;
            S_ST:    drive = {1'b1, i[0]};
            S_OP:    drive = {1'b1, ~i[0]};
            S_PHYAD: drive = {1'b1, PHY_ADDR[3'(3'd4 - i)]};
            S_REGAD: drive = {1'b1, REG_ADDR[3'(3'd4 - i)]};
            default: drive = 2'b00;
        endcase
    endfunction

    // A floating (pulled-up) line reads as 1.
    assign mdio_in = (MDIO == 1'b0) ? 1'b0 : 1'b1;

    assign rise = (div_q == DIV_W'(HALF - 1));
    assign fall = (div_q == DIV_W'(CLK_DIV - 1));

    // Slot sequencing, read shifting and drive selection.
    always_comb begin
        div_d   = fall ? '0 : div_q + 1'b1;
        mdc_d   = mdc_q;
        state_d = state_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        rdata_d = rdata_q;
        valid_d = 1'b0;
        pend_d  = 1'b0;

        if (rise) begin
            mdc_d = 1'b1;
            if (state_q == S_DATA) begin
                shift_d = {shift_q[14:0], mdio_in};
                pend_d  = (bit_q == BIT_W'(15));
            end
        end

        if (fall) begin
            mdc_d = 1'b0;
            if (bit_q == last_idx(state_q)) begin
                state_d = next_seg(state_q);
                bit_d   = '0;
            end else begin
                bit_d = bit_q + 1'b1;
            end
        end

        // Publish one clk after the D0 sample.
        if (pend_q) begin
            rdata_d = shift_q;
            valid_d = 1'b1;
        end

        // Drive follows the slot being entered so it changes with MDC falling.
        {oe_d, out_d} = drive(state_d, bit_d[2:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_PRE;
            div_q   <= '0;
            bit_q   <= '0;
            mdc_q   <= 1'b0;
            oe_q    <= 1'b0;
            out_q   <= 1'b0;
            shift_q <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
            pend_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            mdc_q   <= mdc_d;
            oe_q    <= oe_d;
            out_q   <= out_d;
            shift_q <= shift_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
            pend_q  <= pend_d;
        end
    end

    assign MDC         = mdc_q;
    assign MDIO        = oe_q ? out_q : 1'bz;
    assign rdata       = rdata_q;
    assign rdata_valid = valid_q;

endmodule

// File: tb/tb_mii_mdio_poller.sv
// Bench for mii_mdio_poller: two instances (defaults, and CLK_DIV=4 with
// PHYAD=1F/REGAD=02) each with a behavioural PHY that decodes the command
// from the wire and answers with random data.
module tb_mii_mdio_poller;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic rst_seen;
    int   tests;
    int   fails;

    wire  mdio0, mdio1;
    pullup (mdio0);
    pullup (mdio1);
    logic [1:0] phy_oe, phy_bit, phy_en;
    assign mdio0 = phy_oe[0] ? phy_bit[0] : 1'bz;
    assign mdio1 = phy_oe[1] ? phy_bit[1] : 1'bz;

    logic        mdc0, mdc1, v0, v1;
    logic [15:0] rd0, rd1;

    mii_mdio_poller u0 (
        .clk(clk), .rst(rst), .MDC(mdc0), .MDIO(mdio0), .rdata(rd0), .rdata_valid(v0)
    );

    mii_mdio_poller #(.CLK_DIV(4), .PHY_ADDR(5'h1F), .REG_ADDR(5'h02)) u1 (
        .clk(clk), .rst(rst), .MDC(mdc1), .MDIO(mdio1), .rdata(rd1), .rdata_valid(v1)
    );

    wire [1:0] mdc_v  = {mdc1, mdc0};
    wire [1:0] mdio_v = {mdio1, mdio0};
    wire [1:0] val_v  = {v1, v0};

    // Event records per instance, cleared whenever reset is seen.
    int          cyc    [2];
    int          nrise  [2];
    int          rise_t [2][64];
    logic        rise_b [2][64];
    int          got_n  [2];
    int          got_t  [2][32];
    logic [15:0] got_v  [2][32];
    int          exp_n  [2];
    logic [15:0] exp_v  [2][32];
    logic [1:0]  prev_mdc;

    // PHY model state.
    logic [14:0] hist  [2];
    logic        busy  [2];
    logic        talk  [2];
    int          cnt   [2];
    logic [15:0] cur   [2];
    logic        first [2];

    always @(posedge clk) rst_seen <= rst;

    // Monitor and PHY: act on the settled values after each rising edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            logic [14:0] pat;
            logic [15:0] rdk;
            pat = (k == 0) ? {1'b1, 4'b0110, 5'h00, 5'h01} : {1'b1, 4'b0110, 5'h1F, 5'h02};
            rdk = (k == 0) ? rd0 : rd1;
            if (rst_seen) begin
                cyc[k] = 0; nrise[k] = 0; got_n[k] = 0; exp_n[k] = 0;
                prev_mdc[k] = 1'b0; hist[k] = '0; busy[k] = 1'b0; talk[k] = 1'b0;
                cnt[k] = 0; first[k] = 1'b1; phy_oe[k] = 1'b0; phy_bit[k] = 1'b0;
            end else begin
                cyc[k]++;
                if (val_v[k] && got_n[k] < 32) begin
                    got_t[k][got_n[k]] = cyc[k];
                    got_v[k][got_n[k]] = rdk;
                    got_n[k]++;
                end
                if (mdc_v[k] && !prev_mdc[k]) begin
                    if (nrise[k] < 64) begin
                        rise_t[k][nrise[k]] = cyc[k];
                        rise_b[k][nrise[k]] = mdio_v[k];
                    end
                    nrise[k]++;
                    if (!busy[k]) begin
                        hist[k] = {hist[k][13:0], mdio_v[k]};
                        if (hist[k] == pat) begin
                            busy[k] = 1'b1;
                            cnt[k]  = 0;
                            talk[k] = phy_en[k];
                            if (!phy_en[k]) cur[k] = 16'hFFFF;
                            else if (first[k]) cur[k] = 16'h1234;
                            else cur[k] = 16'($urandom);
                            if (phy_en[k]) first[k] = 1'b0;
                            if (exp_n[k] < 32) exp_v[k][exp_n[k]] = cur[k];
                            exp_n[k]++;
                        end
                    end else begin
                        cnt[k]++;
                        if (cnt[k] >= 18) begin
                            phy_oe[k] = 1'b0;
                            busy[k]   = 1'b0;
                            hist[k]   = '0;
                        end else if (cnt[k] >= 2) begin
                            phy_oe[k]  = talk[k];
                            phy_bit[k] = cur[k][4'(17 - cnt[k])];
                        end
                    end
                end
                prev_mdc[k] = mdc_v[k];
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Compare one post-reset epoch of an instance against the frame rules.
    task automatic check_epoch(input int k);
        int          d;
        int          h;
        int          n;
        logic [45:0] cmd;
        d   = (k == 0) ? 8 : 4;
        h   = d / 2;
        cmd = (k == 0) ? {32'hFFFF_FFFF, 4'b0110, 5'h00, 5'h01}
                       : {32'hFFFF_FFFF, 4'b0110, 5'h1F, 5'h02};
        check($sformatf("inst%0d rise_count", k), 32'(nrise[k] >= 64), 32'd1);
        for (int i = 0; i < 64; i++)
            check($sformatf("inst%0d rise_t[%0d]", k, i), 32'(rise_t[k][i]), 32'(h + i * d));
        for (int i = 0; i < 46; i++)
            check($sformatf("inst%0d cmd_bit[%0d]", k, i), 32'(rise_b[k][i]), 32'(cmd[45 - i]));
        check($sformatf("inst%0d valid_count", k), 32'(got_n[k] >= 5), 32'd1);
        check($sformatf("inst%0d phy_frames", k), 32'(exp_n[k] >= got_n[k]), 32'd1);
        check($sformatf("inst%0d first_rdata", k), 32'(got_v[k][0]), 32'h1234);
        n = (got_n[k] < 32) ? got_n[k] : 32;
        for (int j = 0; j < n; j++) begin
            check($sformatf("inst%0d valid_t[%0d]", k, j), 32'(got_t[k][j]),
                  32'(h + 63 * d + 1 + j * 64 * d));
            check($sformatf("inst%0d rdata[%0d]", k, j), 32'(got_v[k][j]), 32'(exp_v[k][j]));
        end
    endtask

    initial begin
        tests  = 0;
        fails  = 0;
        rst    = 1'b1;
        phy_en = 2'b11;
        repeat (4) @(negedge clk);
        check("rst mdc0", 32'(mdc0), 32'd0);
        check("rst mdc1", 32'(mdc1), 32'd0);
        check("rst rdata0", 32'(rd0), 32'd0);
        check("rst rdata1", 32'(rd1), 32'd0);
        check("rst valid0", 32'(v0), 32'd0);
        check("rst valid1", 32'(v1), 32'd0);
        check("rst mdio0", 32'(mdio0), 32'd1);
        check("rst mdio1", 32'(mdio1), 32'd1);

        // Polling with the PHY absent for a stretch (reads return the pull-up).
        rst = 1'b0;
        repeat (1500) @(negedge clk);
        phy_en = 2'b00;
        repeat (600) @(negedge clk);
        phy_en = 2'b11;
        repeat (900) @(negedge clk);
        check_epoch(0);
        check_epoch(1);

        // One-clk reset in the middle of instance 0's DATA field.
        for (int i = 0; i < 2000 && cyc[0] != 3492; i++) @(negedge clk);
        check("mid reset point", 32'(cyc[0]), 32'd3492);
        rst = 1'b1;
        @(negedge clk);
        #1;
        check("mid rst mdc0", 32'(mdc0), 32'd0);
        check("mid rst mdc1", 32'(mdc1), 32'd0);
        check("mid rst mdio0", 32'(mdio0), 32'd1);
        check("mid rst mdio1", 32'(mdio1), 32'd1);
        check("mid rst valid0", 32'(v0), 32'd0);
        check("mid rst rdata0", 32'(rd0), 32'd0);
        check("mid rst rdata1", 32'(rd1), 32'd0);
        rst = 1'b0;
        repeat (3000) @(negedge clk);
        check_epoch(0);
        check_epoch(1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
